blake2_msg_feeder: RTL

Host-side driver for the blake2s core byte interface. It takes an arbitrary-length message as a byte stream and slices it into BB-byte blocks for the core. It drives the per-byte index, first/last block flags and the total byte count, and zero-pads the final block. It then collects the digest bytes the core streams back and presents them as an nn-byte result with an end marker.

---
 rtl/blake2_msg_feeder.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/blake2_msg_feeder.sv
// Slices a message byte stream into zero-padded BB-byte blocks for a blake2s core and
// forwards the digest bytes the core streams back, dropping the stale lead-in strobe.
module blake2_msg_feeder #(
    parameter int unsigned BB    = 64,
    parameter int unsigned IDX_W = $clog2(BB),
    parameter int unsigned LL_W  = 64,
    parameter int unsigned NN_W  = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_v_i,
    input  logic [7:0]       in_data_i,
    input  logic             in_last_i,
    input  logic             in_empty_i,
    output logic             in_ready_o,
    input  logic [NN_W-1:0]  nn_i,
    input  logic             core_ready_i,
    output logic             core_data_v_o,
    output logic [IDX_W-1:0] core_data_idx_o,
    output logic [7:0]       core_data_o,
    output logic             core_block_first_o,
    output logic             core_block_last_o,
    output logic [LL_W-1:0]  core_ll_o,
    input  logic             core_h_v_i,
    input  logic [7:0]       core_h_i,
    output logic             res_v_o,
    output logic [7:0]       res_data_o,
    output logic             res_last_o,
    output logic             busy_o
);

    typedef enum logic [2:0] {
        StIdle,
        StStream,
        StPad,
        StWaitF,
        StWaitRes,
        StRes
    } state_t;

    localparam logic [IDX_W-1:0] IdxMax = IDX_W'(BB - 1);

    state_t           state_q;
    logic [IDX_W-1:0] idx_q;     // index of the next byte to emit
    logic [NN_W-1:0]  nn_q;
    logic [NN_W-1:0]  res_cnt_q;
    logic             accept;

    assign in_ready_o = core_ready_i & ((state_q == StIdle) | (state_q == StStream));
    assign accept     = in_v_i & in_ready_o;
    assign busy_o     = (state_q != StIdle);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q            <= StIdle;
            idx_q              <= '0;
            nn_q               <= '0;
            res_cnt_q          <= '0;
            core_data_v_o      <= 1'b0;
            core_data_idx_o    <= '0;
            core_data_o        <= '0;
            core_block_first_o <= 1'b0;
            core_block_last_o  <= 1'b0;
            core_ll_o          <= '0;
            res_v_o            <= 1'b0;
            res_data_o         <= '0;
            res_last_o         <= 1'b0;
        end else begin
            core_data_v_o <= 1'b0;
            res_v_o       <= 1'b0;
            res_last_o    <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        core_block_first_o <= 1'b1;
                        nn_q               <= nn_i;
                        if (in_empty_i) begin
                            // Zero-length message: one all-pad block, nothing emitted yet
                            core_ll_o         <= '0;
                            core_block_last_o <= 1'b1;
                            idx_q             <= '0;
                            state_q           <= StPad;
                        end else begin
                            core_data_v_o     <= 1'b1;
                            core_data_idx_o   <= '0;
                            core_data_o       <= in_data_i;
                            core_ll_o         <= LL_W'(1);
                            core_block_last_o <= in_last_i;
                            idx_q             <= IDX_W'(1);
                            state_q           <= in_last_i ? StPad : StStream;
                        end
                    end
                end
                StStream: begin
                    if (accept && !in_empty_i) begin
                        core_data_v_o   <= 1'b1;
                        core_data_idx_o <= idx_q;
                        core_data_o     <= in_data_i;
                        core_ll_o       <= core_ll_o + LL_W'(1);
                        if (in_last_i) begin
                            core_block_last_o <= 1'b1;
                        end
                        if (idx_q == IdxMax) begin
                            state_q <= in_last_i ? StWaitRes : StWaitF;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                            if (in_last_i) begin
                                state_q <= StPad;
                            end
                        end
                    end
                end
                StPad: begin
                    core_data_v_o     <= 1'b1;
                    core_data_idx_o   <= idx_q;
                    core_data_o       <= 8'h00;
                    core_block_last_o <= 1'b1;
                    if (idx_q == IdxMax) begin
                        state_q <= StWaitRes;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                StWaitF: begin
                    if (core_ready_i) begin
                        core_block_first_o <= 1'b0;
                        idx_q              <= '0;
                        state_q            <= StStream;
                    end
                end
                StWaitRes: begin
                    // First strobe of the digest burst carries a stale byte
                    if (core_h_v_i) begin
                        res_cnt_q <= '0;
                        state_q   <= StRes;
                    end
                end
                StRes: begin
                    if (core_h_v_i) begin
                        res_v_o    <= 1'b1;
                        res_data_o <= core_h_i;
                        res_cnt_q  <= res_cnt_q + NN_W'(1);
                        if (res_cnt_q + NN_W'(1) == nn_q) begin
                            res_last_o         <= 1'b1;
                            core_block_first_o <= 1'b0;
                            core_block_last_o  <= 1'b0;
                            state_q            <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
